mem_stage: RTL and testbench
============================

# mem_stage

Memory-stage unit of the pipelined RISC-V core: the consumer of the Execute stage's `ALU_result`, `Zero` and `Target` outputs. It holds one EX/MEM entry, performs doubleword loads and stores over a wait-state data-memory handshake, resolves branches from `Zero`, and delivers a one-cycle result pulse to writeback. While a memory access is outstanding it back-pressures Execute through `ex_ready`.

## Interface
- `TIMEOUT`, default 16: maximum number of cycles `dmem_req` may be held without `dmem_ack`. Used only when `MEM_STAGE_TIMEOUT_EN` is defined.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high.
- `ex_valid` input 1: the Execute-side fields are valid this cycle.
- `ex_ready` output 1: the stage can accept an entry; high only in IDLE.
- `ALU_result` input 64: address for loads/stores; result for ALU ops.
- `Zero` input 1: ALU zero flag.
- `Target` input 64: branch target computed by Execute.
- `B` input 64: store data, i.e. rs2.
- `rd` input 5: destination register.
- `MemRead`, `MemWrite`, `Branch`, `MemtoReg`, `RegWrite` inputs, 1 bit each: control bits.
- `dmem_req` output 1: memory request; held until acknowledged.
- `dmem_we` output 1: 1 = store, 0 = load.
- `dmem_addr` output 64: memory address.
- `dmem_wdata` output 64: store data.
- `dmem_ack` input 1: access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` input 64: load data.
- `wb_valid` output 1: one-cycle writeback pulse.
- `wb_rd` output 5: writeback destination register.
- `wb_RegWrite` output 1: writeback enable.
- `wb_result` output 64: writeback value.
- `pc_src` output 1: one-cycle pulse meaning the branch is taken.
- `branch_target` output 64: redirect PC; valid while `pc_src` is high.
- `mem_fault` output 1: one-cycle timeout pulse.

## Operation
- States:
  - IDLE: accepts an entry when `ex_valid && ex_ready`.
  - WAIT: a memory access is outstanding.
  - IDLE is the reset state.
- On acceptance, the stage latches every input field.
  - If `MemRead|MemWrite`, it goes to WAIT and asserts `dmem_req` on the next cycle.
  - Otherwise it stays in IDLE and issues `wb_valid` on the next cycle.
- During WAIT:
  - `dmem_addr`, `dmem_we` and `dmem_wdata` are driven from the latched `ALU_result`, `MemWrite` and `B`, and stay stable while `dmem_req` is high.
  - `dmem_ack` returns the stage to IDLE and deasserts `dmem_req`. On the following cycle the stage pulses `wb_valid`.
- Writeback fields:
  - `wb_result` is `MemtoReg ? captured dmem_rdata : latched ALU_result`.
  - `wb_RegWrite` and `wb_rd` are taken from the latched entry.
  - Stores complete with `wb_valid=1` and the latched `RegWrite`, which is normally 0.
- Branches:
  - If the accepted entry has `Branch && Zero`, `pc_src` pulses on the next cycle and `branch_target` carries the latched `Target`.
  - If `Branch && !Zero`, `pc_src` stays at 0.
- Both `MemRead` and `MemWrite` set: treated as a store.
- `Branch` together with a memory bit: the memory access still occurs, and `pc_src` still pulses one cycle after acceptance.
- `dmem_ack` while in IDLE is ignored.
- No arithmetic is performed; all data paths are 64-bit pass-through.

## Timing
- Reset values:
  - `ex_ready=1`.
  - `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_wdata=0`.
  - `wb_valid=0`, `wb_rd=0`, `wb_RegWrite=0`, `wb_result=0`.
  - `pc_src=0`, `branch_target=0`, `mem_fault=0`.
- Non-memory entry: accepted at edge N; `wb_valid` and `pc_src` are high for cycle N+1 only. A new entry may be accepted at N+1, giving back-to-back throughput of 1 per cycle.
- Memory entry:
  - Accepted at edge N.
  - `dmem_req` rises at N+1 and `ex_ready` falls at N+1.
  - If `dmem_ack` is sampled at edge M (M ≥ N+1; zero-wait ack is allowed), `dmem_req` falls and `ex_ready` rises after M.
  - `wb_valid` is high for the cycle after M.
  - Minimum load-to-writeback latency is 2 cycles.
- `reset` asserted in WAIT: the next edge forces IDLE and `dmem_req=0`. The entry is discarded, and no `wb_valid`, `pc_src` or `mem_fault` is issued for it.

## Configuration
- `MEM_STAGE_TIMEOUT_EN` defined:
  - A counter clears when WAIT is entered and increments each cycle without `dmem_ack`.
  - When it reaches `TIMEOUT`, the stage drops `dmem_req` and returns to IDLE.
  - In the following cycle it pulses both `mem_fault` and `wb_valid`, with `wb_RegWrite=0`.
  - An ack arriving in the same cycle as the timeout wins: no fault is raised.
- Not defined: no counter; WAIT is held indefinitely and `mem_fault` is tied to 0.

## Test plan
- ALU op: `ALU_result=20`, `rd=5`, `RegWrite=1`, `MemtoReg=0` → next cycle `wb_valid=1`, `wb_rd=5`, `wb_result=20`, `ex_ready` stays 1.
- Load at address 0x100, ack after 3 wait cycles with `dmem_rdata=0xDEADBEEF`:
  - `dmem_req` is high for 4 cycles with `dmem_we=0`.
  - `ex_ready` is 0 throughout.
  - Then `wb_result=0xDEADBEEF`.
- Store: `ALU_result=0x200`, `B=0x55`, zero-wait ack → `dmem_we=1`, `dmem_addr=0x200`, `dmem_wdata=0x55`; `wb_valid` two cycles after acceptance with `wb_RegWrite=0`.
- Branch:
  - `Branch=1`, `Zero=1`, `Target=0x508` → `pc_src=1` for one cycle with `branch_target=0x508`.
  - Repeat with `Zero=0` → `pc_src` stays 0.
- Reset asserted on the second WAIT cycle of a load → `dmem_req=0` and `ex_ready=1` after that edge; `wb_valid` never pulses.
- `MEM_STAGE_TIMEOUT_EN` with `TIMEOUT=4` and no ack → `dmem_req` high for 4 cycles, then `mem_fault=1` and `wb_valid=1` with `wb_RegWrite=0`.

Source files
------------

// File: rtl/mem_stage.sv
// EX/MEM stage: latches one Execute entry, runs doubleword load/store over a
// req/ack handshake, resolves branches and pulses writeback. Optional watchdog: MEM_STAGE_TIMEOUT_EN.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] ALU_result,
  input  logic        Zero,
  input  logic [63:0] Target,
  input  logic [63:0] B,
  input  logic [4:0]  rd,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWrite,
  output logic [63:0] wb_result,
  output logic        pc_src,
  output logic [63:0] branch_target,
  output logic        mem_fault
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;

  logic        accept, is_mem, ack_hit, tmo_hit;
  logic [63:0] addr_q, wdata_q;
  logic        we_q, m2r_q, rw_q;
  logic [4:0]  rd_q;

  assign ex_ready   = (state == IDLE);
  assign dmem_req   = (state == WAIT);
  assign accept     = ex_valid && ex_ready;
  assign is_mem     = MemRead || MemWrite;
  assign ack_hit    = (state == WAIT) && dmem_ack;
  // Memory port is driven straight from the latched entry, so it stays put while req is up.
  assign dmem_addr  = addr_q;
  assign dmem_we    = we_q;
  assign dmem_wdata = wdata_q;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  // Ack in the same cycle as expiry takes priority over the fault.
  assign tmo_hit = (state == WAIT) && !dmem_ack && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= tmo_hit;
      if (accept && is_mem)                    cnt_q <= '0;
      else if ((state == WAIT) && !dmem_ack)   cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign tmo_hit   = 1'b0;
  assign mem_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && is_mem)    state_nx = WAIT;
      WAIT:    if (ack_hit || tmo_hit)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      m2r_q         <= 1'b0;
      rw_q          <= 1'b0;
      rd_q          <= '0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_RegWrite   <= 1'b0;
      wb_result     <= '0;
      pc_src        <= 1'b0;
      branch_target <= '0;
    end else begin
      wb_valid <= 1'b0;
      pc_src   <= 1'b0;
      if (accept) begin
        addr_q  <= ALU_result;
        wdata_q <= B;
        we_q    <= MemWrite;
        m2r_q   <= MemtoReg;
        rw_q    <= RegWrite;
        rd_q    <= rd;
        if (Branch && Zero) begin
          pc_src        <= 1'b1;
          branch_target <= Target;
        end
        if (!is_mem) begin
          wb_valid    <= 1'b1;
          wb_rd       <= rd;
          wb_RegWrite <= RegWrite;
          wb_result   <= ALU_result;
        end
      end
      if (ack_hit) begin
        wb_valid    <= 1'b1;
        wb_rd       <= rd_q;
        wb_RegWrite <= rw_q;
        wb_result   <= m2r_q ? dmem_rdata : addr_q;
      end else if (tmo_hit) begin
        // Timed-out access completes without a register write.
        wb_valid    <= 1'b1;
        wb_rd       <= rd_q;
        wb_RegWrite <= 1'b0;
        wb_result   <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random entries against
// a transaction-level model of the stage's timing rules.
module tb_mem_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [63:0] ALU_result = '0, Target = '0, B = '0;
  logic        Zero = 1'b0;
  logic [4:0]  rd = '0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, Branch = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic        wb_valid, wb_RegWrite, pc_src, mem_fault;
  logic [4:0]  wb_rd;
  logic [63:0] wb_result, branch_target;

  int errs = 0, checks = 0;

  mem_stage #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALU_result(ALU_result), .Zero(Zero), .Target(Target), .B(B), .rd(rd),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .wb_result(wb_result),
    .pc_src(pc_src), .branch_target(branch_target), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] alu, tgt, b;
    logic [4:0]  rd;
    logic        mr, mw, br, z, m2r, rw;
  } ent_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    ALU_result = {$urandom, $urandom}; B = {$urandom, $urandom}; Target = {$urandom, $urandom};
    rd = 5'($urandom); Zero = 1'($urandom); RegWrite = 1'($urandom); MemtoReg = 1'($urandom);
    MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0;
  endtask

  // Issue one entry and follow it to completion. d = ack delay in WAIT cycles.
  task automatic run(input ent_t e, input int d, input logic [63:0] rdata);
    bit mem, take, done;
    int k;
    mem  = e.mr | e.mw;
    take = e.br & e.z;
    chk("ready_before", ex_ready, 1);
    ALU_result = e.alu; Target = e.tgt; B = e.b; rd = e.rd; MemRead = e.mr; MemWrite = e.mw;
    Branch = e.br; Zero = e.z; MemtoReg = e.m2r; RegWrite = e.rw; ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
    scramble();
    chk("pc_src", pc_src, take);
    if (take) chk("branch_target", branch_target, e.tgt);
    if (!mem) begin
      chk("alu_wb_valid", wb_valid, 1);
      chk("alu_wb_rd", wb_rd, e.rd);
      chk("alu_wb_we", wb_RegWrite, e.rw);
      chk("alu_wb_result", wb_result, e.alu);
      chk("alu_ready", ex_ready, 1);
      chk("alu_req", dmem_req, 0);
      return;
    end
    done = 0;
    k = 0;
    while (!done) begin
      chk("wait_req", dmem_req, 1);
      chk("wait_ready", ex_ready, 0);
      chk("wait_we", dmem_we, e.mw);
      chk("wait_addr", dmem_addr, e.alu);
      if (e.mw) chk("wait_wdata", dmem_wdata, e.b);
      chk("wait_wb_valid", wb_valid, 0);
      if (k > 0) chk("wait_pc_src", pc_src, 0);
      dmem_ack = (k == d);
      dmem_rdata = rdata;
      step();
      dmem_ack = 1'b0;
      dmem_rdata = {$urandom, $urandom};
      if (k == d) begin
        done = 1;
        chk("ack_req", dmem_req, 0);
        chk("ack_ready", ex_ready, 1);
        chk("ack_wb_valid", wb_valid, 1);
        chk("ack_wb_rd", wb_rd, e.rd);
        chk("ack_wb_we", wb_RegWrite, e.rw);
        chk("ack_wb_result", wb_result, e.m2r ? rdata : e.alu);
        chk("ack_fault", mem_fault, 0);
      end
`ifdef MEM_STAGE_TIMEOUT_EN
      else if (k == TMO - 1) begin
        done = 1;
        chk("tmo_req", dmem_req, 0);
        chk("tmo_ready", ex_ready, 1);
        chk("tmo_wb_valid", wb_valid, 1);
        chk("tmo_fault", mem_fault, 1);
        chk("tmo_wb_we", wb_RegWrite, 0);
      end
`endif
      k++;
    end
    step();
    chk("post_wb_valid", wb_valid, 0);
    chk("post_fault", mem_fault, 0);
    chk("post_pc_src", pc_src, 0);
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    int kind;
    kind  = $urandom_range(0, 4);
    e.alu = {$urandom, $urandom}; e.tgt = {$urandom, $urandom}; e.b = {$urandom, $urandom};
    e.rd  = 5'($urandom);
    e.z   = 1'($urandom);
    e.br  = (kind == 3) || (kind == 4 && 1'($urandom));
    e.mr  = (kind == 1) || (kind == 4 && 1'($urandom));
    e.mw  = (kind == 2) || (kind == 4 && 1'($urandom));
    e.m2r = e.mr & ~e.mw;
    e.rw  = (kind == 0) || e.m2r || (kind == 4 && 1'($urandom));
    return e;
  endfunction

  initial begin
    ent_t e;
    step(); step();
    chk("rst_ready", ex_ready, 1);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_we", wb_RegWrite, 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_pc_src", pc_src, 0);
    chk("rst_target", branch_target, 0);
    chk("rst_fault", mem_fault, 0);
    reset = 1'b0;
    step();

    e = '0; e.alu = 64'd20; e.rd = 5'd5; e.rw = 1'b1;
    run(e, 0, '0);
    step();
    chk("alu_pulse_end", wb_valid, 0);

    e = '0; e.alu = 64'h100; e.rd = 5'd7; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1;
    run(e, 3, 64'hDEADBEEF);

    e = '0; e.alu = 64'h200; e.b = 64'h55; e.mw = 1'b1; e.rd = 5'd3;
    run(e, 0, 64'h1234);

    e = '0; e.br = 1'b1; e.z = 1'b1; e.tgt = 64'h508;
    run(e, 0, '0);
    e.z = 1'b0;
    run(e, 0, '0);

    // Back-to-back ALU entries, one per cycle.
    for (int i = 0; i < 4; i++) begin
      e = '0; e.alu = 64'(i * 3 + 1); e.rd = 5'(i + 1); e.rw = 1'b1;
      run(e, 0, '0);
    end
    step();

    // Reset on the second WAIT cycle discards the load.
    ALU_result = 64'h300; MemRead = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; Branch = 1'b0;
    ex_valid = 1'b1;
    step();
    ex_valid = 1'b0; MemRead = 1'b0;
    chk("rw_req1", dmem_req, 1);
    step();
    chk("rw_req2", dmem_req, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_req", dmem_req, 0);
    chk("rw_ready", ex_ready, 1);
    chk("rw_wb_valid", wb_valid, 0);
    step();
    chk("rw_wb_valid2", wb_valid, 0);
    chk("rw_fault", mem_fault, 0);
    chk("rw_pc_src", pc_src, 0);

`ifdef MEM_STAGE_TIMEOUT_EN
    e = '0; e.alu = 64'h400; e.mr = 1'b1; e.m2r = 1'b1; e.rw = 1'b1; e.rd = 5'd9;
    run(e, 1000, '0);
`endif

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("idle_ack_wb", wb_valid, 0);
        chk("idle_ack_req", dmem_req, 0);
        chk("idle_ack_ready", ex_ready, 1);
      end
      run(rnd_ent(), $urandom_range(0, 5), {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
